uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive stage sitting directly downstream of the baud generator; consumes its oversample tick (baudx16_tick).
- Synchronises the asynchronous serial line, detects the start bit, mid-bit samples data/parity/stop, and presents the received byte on a valid/ready handshake to the bus-side register block.
- Drives rx_busy_o back to the baud generator so the baud rate cannot change mid-frame.

Parameters:
- DataBits, 8, data bits per frame (5..8), sent LSB first.
- OverSampleRate, 16, ticks per bit period; must be even and >= 4; matches the baud generator setting.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- baudx16_tick_i  input  1  one-cycle oversample tick from the baud generator
- rx_i  input  1  asynchronous serial line; idle high
- parity_en_i  input  1  1 = frame carries a parity bit after the data bits
- parity_odd_i  input  1  1 = odd parity, 0 = even; ignored when parity_en_i = 0
- rx_ready_i  input  1  consumer accepts the byte
- rx_data_o  output  DataBits  received byte
- rx_valid_o  output  1  byte available; held until accepted
- rx_busy_o  output  1  frame in progress (state != IDLE); feeds the baud generator
- frame_err_o  output  1  stop bit sampled low; qualifies the current byte
- parity_err_o  output  1  parity mismatch; qualifies the current byte
- overrun_o  output  1  sticky: a byte completed while rx_valid_o was still high

Behaviour:
- Reset (rst_i = 1 at a clk_i edge):
  - State = IDLE; all counters = 0.
  - Outputs: rx_data_o = 0, rx_valid_o = 0, rx_busy_o = 0, frame_err_o = 0, parity_err_o = 0, overrun_o = 0.
  - Synchroniser flops = 1 (line idle).
  - Reset mid-frame abandons the frame with no valid pulse.
- Synchroniser: rx_i passes through 2 flops; all logic uses the synchronised value rx_s.
- Tick counter tick_cnt:
  - Width $clog2(OverSampleRate).
  - Advances only on cycles with baudx16_tick_i = 1. No action occurs on non-tick cycles except the IDLE start detect.
- States:
  - IDLE: rx_s = 0 on any cycle → START, tick_cnt = 0.
  - START: on each tick, tick_cnt++. On the tick where tick_cnt == OverSampleRate/2-1 (mid start bit):
    - rx_s = 0 → DATA, tick_cnt = 0, bit_cnt = 0.
    - rx_s = 1 → IDLE (glitch rejected; no output change).
  - DATA: on the tick where tick_cnt == OverSampleRate-1:
    - Sample rx_s into the shift register MSB; shift right; tick_cnt = 0; bit_cnt++.
    - After DataBits samples → PARITY if parity_en_i, else STOP.
    - Shift register is DataBits wide, so the first bit received ends up in bit 0.
  - PARITY: at the full-bit tick, sample the parity bit.
    - perr = (XOR of data bits XOR sampled bit) != parity_odd_i.
    - Then → STOP, tick_cnt = 0.
  - STOP: at the full-bit tick, sample the stop bit, then →IDLE the same cycle. Returning at mid-stop allows back-to-back frames.
- Completion, registered on the STOP sample cycle, visible the next cycle:
  - rx_data_o = shift register.
  - frame_err_o = ~stop_sample.
  - parity_err_o = perr (0 when parity disabled).
  - rx_valid_o = 1.
- Overrun:
  - If rx_valid_o = 1 and the handshake does not complete on the completion cycle: set overrun_o.
  - The new byte and error flags still overwrite the old ones; rx_valid_o stays 1.
- Handshake: rx_valid_o & rx_ready_i on a clk_i edge → rx_valid_o = 0 next cycle, unless a completion occurs on that same cycle. Completion wins: valid stays 1 with the new data and no overrun.
- overrun_o clears only on reset or on an accepted handshake.
- Config inputs parity_en_i / parity_odd_i are sampled live. Software changes them only while rx_busy_o = 0.
- Break condition (line held low): treated as a 0x00 byte with frame_err_o = 1. The FSM then waits in IDLE and re-enters START immediately while the line stays low.
- Latency: rx_valid_o rises 3 cycles after the synchroniser input edge plus (1 + DataBits [+1]) bit periods plus half a bit.

Test Plan:
- Tick every cycle (OverSampleRate = 16), no parity, send 0xA5 with a good stop → rx_data_o = 0xA5, rx_valid_o = 1, frame_err_o = 0, parity_err_o = 0. rx_busy_o is high from start detect until the STOP sample.
- Low pulse of 4 ticks on idle line → FSM returns to IDLE at the mid-start sample, rx_valid_o stays 0, rx_busy_o high only during START.
- Parity even enabled, send 0x03 with parity bit 1 → parity_err_o = 1; with parity bit 0 → parity_err_o = 0. Odd parity with 0x01 and parity bit 0 → parity_err_o = 0.
- Send 0x55 with stop bit 0 → frame_err_o = 1, rx_data_o = 0x55. Hold the line low 20 bit periods → bytes of 0x00 with frame_err_o = 1; no hang.
- Two back-to-back frames 0x11, 0x22 with rx_ready_i = 0:
  - Expect overrun_o = 1, rx_data_o = 0x22.
  - Raise rx_ready_i for 1 cycle → rx_valid_o = 0, overrun_o = 0.
  - Also: ready asserted on the exact completion cycle → valid stays 1 with the new byte, no overrun.
- Divisor 27 ticks (50 MHz, 115200 baud, bit period 432 clk), assert rst_i mid-DATA → all outputs 0 the next cycle. The following clean frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-flop synchroniser, start detect, mid-bit sampling
// and a valid/ready byte output with frame, parity and sticky overrun flags.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DataBits       = 8,
  parameter int OverSampleRate = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                baudx16_tick_i,
  input  logic                rx_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  input  logic                rx_ready_i,
  output logic [DataBits-1:0] rx_data_o,
  output logic                rx_valid_o,
  output logic                rx_busy_o,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                overrun_o
);

  localparam int TW = $clog2(OverSampleRate);
  localparam int BW = $clog2(DataBits + 1);
  localparam logic [TW-1:0] MidTick  = TW'(OverSampleRate / 2 - 1);
  localparam logic [TW-1:0] FullTick = TW'(OverSampleRate - 1);
  localparam logic [BW-1:0] LastBit  = BW'(DataBits - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state, state_nxt;

  logic                rx_meta, rx_s;
  logic [TW-1:0]       tick_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [DataBits-1:0] shift;
  logic                perr;

  logic mid_tick, full_tick;
  logic cnt_clr, cnt_inc, frame_begin, shift_en, par_en, done;

  assign mid_tick  = baudx16_tick_i && (tick_cnt == MidTick);
  assign full_tick = baudx16_tick_i && (tick_cnt == FullTick);

  // Synchroniser resets to the idle line level so reset never fakes a start bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rx_s)     state_nxt = START;
      START:   if (mid_tick)  state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (full_tick && (bit_cnt == LastBit))
                              state_nxt = parity_en_i ? PARITY : STOP;
      PARITY:  if (full_tick) state_nxt = STOP;
      STOP:    if (full_tick) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_busy_o   = (state != IDLE);
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    frame_begin = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: cnt_clr = 1'b1;
      START: begin
        if (mid_tick) begin
          cnt_clr     = 1'b1;
          frame_begin = !rx_s;
        end else begin
          cnt_inc = baudx16_tick_i;
        end
      end
      DATA: begin
        if (full_tick) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
        end else begin
          cnt_inc = baudx16_tick_i;
        end
      end
      PARITY: begin
        if (full_tick) begin
          cnt_clr = 1'b1;
          par_en  = 1'b1;
        end else begin
          cnt_inc = baudx16_tick_i;
        end
      end
      STOP: begin
        if (full_tick) begin
          cnt_clr = 1'b1;
          done    = 1'b1;
        end else begin
          cnt_inc = baudx16_tick_i;
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      perr         <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (cnt_clr)      tick_cnt <= '0;
      else if (cnt_inc) tick_cnt <= tick_cnt + 1'b1;

      // perr is cleared per frame so it reads 0 whenever parity is disabled.
      if (frame_begin) begin
        bit_cnt <= '0;
        perr    <= 1'b0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (shift_en) shift <= {rx_s, shift[DataBits-1:1]};
      if (par_en)   perr  <= ((^shift) ^ rx_s) != parity_odd_i;

      // A completion always wins over a same-cycle accept: the new byte stays valid.
      if (done) begin
        rx_data_o    <= shift;
        frame_err_o  <= ~rx_s;
        parity_err_o <= perr;
        rx_valid_o   <= 1'b1;
        if (rx_valid_o && rx_ready_i) overrun_o <= 1'b0;
        else if (rx_valid_o)          overrun_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
        overrun_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx; expected bytes and flags come
// from a frame-level model (bit list, ones count, completion latency).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DB  = 8;
  localparam int OSR = 16;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          tick = 1'b0;
  logic          rx   = 1'b1;
  logic          pen  = 1'b0;
  logic          podd = 1'b0;
  logic          rdy  = 1'b0;
  logic [DB-1:0] data;
  logic          valid, busy, ferr, perr, ovr;

  int div    = 1;
  int errors = 0;
  int checks = 0;

  uart_rx #(.DataBits(DB), .OverSampleRate(OSR)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .baudx16_tick_i(tick),
    .rx_i          (rx),
    .parity_en_i   (pen),
    .parity_odd_i  (podd),
    .rx_ready_i    (rdy),
    .rx_data_o     (data),
    .rx_valid_o    (valid),
    .rx_busy_o     (busy),
    .frame_err_o   (ferr),
    .parity_err_o  (perr),
    .overrun_o     (ovr)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clk);
      tick = (tcnt == 0);
      tcnt = (tcnt + 1 >= div) ? 0 : tcnt + 1;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [DB-1:0] d, input logic pe,
                                    input logic po, input logic pb);
    int ones;
    ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    return pe && (((ones + int'(pb)) % 2) != int'(po));
  endfunction

  // Drives one frame from the current negedge; optional ready pulse, abort, and latency checks.
  task automatic send_frame(input logic [DB-1:0] d, input logic pb, input logic sb,
                            input int ready_at, input int abort_at, input bit timed);
    logic bits[$];
    int   bp, lat;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pb);
    bits.push_back(sb);
    bp  = OSR * div;
    lat = 3 + (1 + DB + int'(pen)) * OSR + OSR / 2;
    for (int c = 0; c < bits.size() * bp; c++) begin
      if (c == abort_at) break;
      rx  = bits[c / bp];
      rdy = (c == ready_at);
      if (timed) begin
        if (c == 2) check("busy_before_detect", 32'(busy), 0);
        if (c == 3) check("busy_at_detect", 32'(busy), 1);
        if (c == lat - 1) begin
          check("busy_before_stop_sample", 32'(busy), 1);
          check("valid_before_latency", 32'(valid), 0);
        end
        if (c == lat) begin
          check("busy_after_stop_sample", 32'(busy), 0);
          check("valid_at_latency", 32'(valid), 1);
        end
      end
      @(negedge clk);
    end
    rdy = 1'b0;
    if (abort_at < 0) rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [DB-1:0] d, input logic pb,
                              input logic sb, input logic ov);
    check({tag, "_valid"},      32'(valid), 1);
    check({tag, "_data"},       32'(data),  32'(d));
    check({tag, "_frame_err"},  32'(ferr),  32'(!sb));
    check({tag, "_parity_err"}, 32'(perr),  32'(exp_perr(d, pen, podd, pb)));
    check({tag, "_overrun"},    32'(ovr),   32'(ov));
  endtask

  task automatic accept();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    check("accept_valid", 32'(valid), 0);
    check("accept_overrun", 32'(ovr), 0);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_not_hung"}, 32'(busy), 0);
  endtask

  initial begin : main
    logic [DB-1:0] d;
    logic          pb, sb;
    int            lat_np;
    lat_np = 3 + (1 + DB) * OSR + OSR / 2;

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(valid), 0);
    check("reset_data", 32'(data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_frame_err", 32'(ferr), 0);
    check("reset_parity_err", 32'(perr), 0);
    check("reset_overrun", 32'(ovr), 0);
    rst = 1'b0;
    idle(4);

    send_frame(8'hA5, 1'b0, 1'b1, -1, -1, 1'b1);
    expect_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    accept();

    for (int c = 0; c < 24; c++) begin
      rx = (c < 4) ? 1'b0 : 1'b1;
      if (c == 3)  check("glitch_busy_in_start", 32'(busy), 1);
      if (c == 10) check("glitch_busy_before_mid", 32'(busy), 1);
      if (c == 11) check("glitch_idle_after_mid", 32'(busy), 0);
      @(negedge clk);
    end
    check("glitch_no_valid", 32'(valid), 0);

    pen = 1'b1; podd = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1, -1, -1, 1'b1);
    expect_frame("even_03_p1", 8'h03, 1'b1, 1'b1, 1'b0);
    check("even_03_p1_perr_set", 32'(perr), 1);
    accept();
    send_frame(8'h03, 1'b0, 1'b1, -1, -1, 1'b0);
    expect_frame("even_03_p0", 8'h03, 1'b0, 1'b1, 1'b0);
    check("even_03_p0_perr_clear", 32'(perr), 0);
    accept();
    podd = 1'b1;
    send_frame(8'h01, 1'b0, 1'b1, -1, -1, 1'b0);
    expect_frame("odd_01_p0", 8'h01, 1'b0, 1'b1, 1'b0);
    check("odd_01_p0_perr_clear", 32'(perr), 0);
    accept();
    pen = 1'b0; podd = 1'b0;

    send_frame(8'h55, 1'b0, 1'b0, -1, -1, 1'b0);
    expect_frame("stop_low", 8'h55, 1'b0, 1'b0, 1'b0);
    idle(2 * OSR);
    accept();

    // Break: two all-zero frames complete while the line is held low.
    for (int c = 0; c < 20 * OSR; c++) begin
      rx = 1'b0;
      @(negedge clk);
    end
    check("break_valid", 32'(valid), 1);
    check("break_data", 32'(data), 0);
    check("break_frame_err", 32'(ferr), 1);
    check("break_overrun", 32'(ovr), 1);
    rx = 1'b1;
    wait_idle("break", 40 * OSR);
    idle(2 * OSR);
    accept();

    send_frame(8'h11, 1'b0, 1'b1, -1, -1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, -1, -1, 1'b0);
    expect_frame("overrun", 8'h22, 1'b0, 1'b1, 1'b1);
    accept();

    send_frame(8'h11, 1'b0, 1'b1, -1, -1, 1'b0);
    send_frame(8'h33, 1'b0, 1'b1, lat_np - 1, -1, 1'b0);
    expect_frame("ready_at_completion", 8'h33, 1'b0, 1'b1, 1'b0);
    accept();

    for (int k = 0; k < 8; k++) begin
      d    = DB'($urandom);
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      pb   = 1'($urandom_range(0, 1));
      sb   = ($urandom_range(0, 3) != 0);
      send_frame(d, pb, sb, -1, -1, (k < 2));
      expect_frame("random", d, pb, sb, 1'b0);
      idle(2 * OSR);
      accept();
    end
    pen = 1'b0; podd = 1'b0;

    div = 27;
    idle(2 * OSR * div);
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1, 1'b0);
    expect_frame("div27", 8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, -1, 4 * OSR * div, 1'b0);
    check("mid_data_busy", 32'(busy), 1);
    rx  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("midreset_valid", 32'(valid), 0);
    check("midreset_data", 32'(data), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_frame_err", 32'(ferr), 0);
    check("midreset_parity_err", 32'(perr), 0);
    check("midreset_overrun", 32'(ovr), 0);
    rst = 1'b0;
    idle(2 * OSR * div);
    check("post_reset_idle", 32'(busy), 0);
    check("post_reset_no_valid", 32'(valid), 0);
    send_frame(8'hC3, 1'b0, 1'b1, -1, -1, 1'b0);
    expect_frame("after_reset", 8'hC3, 1'b0, 1'b1, 1'b0);
    accept();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
